// File: rtl/transfer_datapath.sv
// Register-transfer datapath: PC/SP/MA/MD/IR/A/AP/OUT plus program/data RAM,
// one transfer per clock as selected by the control unit's command bus.
module transfer_datapath #(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] SP_RESET = '1
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic [3:0]        i_transfer_cmd,
    input  logic              i_inc_pc,
    input  logic [1:0]        i_inc_dec_sp,
    input  logic              i_mem_we,
    input  logic              i_dst_ap,
    input  logic [DATA_W-1:0] i_alu_result,
    input  logic [DATA_W-1:0] i_in_data,
    input  logic              i_out_ready,
    input  logic              i_load_en,
    input  logic [ADDR_W-1:0] i_load_addr,
    input  logic [DATA_W-1:0] i_load_data,
    output logic [DATA_W-1:0] o_opcode,
    output logic [DATA_W-1:0] o_a,
    output logic [DATA_W-1:0] o_ap,
    output logic [DATA_W-1:0] o_md,
    output logic [ADDR_W-1:0] o_pc,
    output logic [ADDR_W-1:0] o_sp,
    output logic [DATA_W-1:0] o_out_data,
    output logic              o_out_valid,
    output logic              o_out_overrun
);

    localparam logic [3:0] CMD_MA_PC  = 4'h1;
    localparam logic [3:0] CMD_MD_MEM = 4'h2;
    localparam logic [3:0] CMD_IR_MD  = 4'h3;
    localparam logic [3:0] CMD_MA_MD  = 4'h4;
    localparam logic [3:0] CMD_R_MD   = 4'h5;
    localparam logic [3:0] CMD_MA_AP  = 4'h6;
    localparam logic [3:0] CMD_MA_SP  = 4'h7;
    localparam logic [3:0] CMD_MD_R   = 4'h8;
    localparam logic [3:0] CMD_MEM_MD = 4'h9;
    localparam logic [3:0] CMD_R_ALU  = 4'hA;
    localparam logic [3:0] CMD_PC_MD  = 4'hB;
    localparam logic [3:0] CMD_A_IN   = 4'hC;
    localparam logic [3:0] CMD_OUT_A  = 4'hD;
    localparam logic [3:0] CMD_PC_AP  = 4'hE;
    localparam logic [3:0] CMD_MD_PC  = 4'hF;

    logic [ADDR_W-1:0] pc, sp, ma;
    logic [DATA_W-1:0] md, ir, a, ap, out_q;
    logic              out_valid, overrun;
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rd_data;
    logic              dp_we;

    assign rd_data = mem[ma];
    assign dp_we   = (i_transfer_cmd == CMD_MEM_MD) || i_mem_we;

    // RAM is never reset so a preload made while the core is held in reset survives
    always_ff @(posedge i_clk) begin
        if (i_load_en)
            mem[i_load_addr] <= i_load_data;
        else if (dp_we)
            mem[ma] <= md;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            pc        <= '0;
            sp        <= SP_RESET;
            ma        <= '0;
            md        <= '0;
            ir        <= '0;
            a         <= '0;
            ap        <= '0;
            out_q     <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            // jump targets override the sequential increment
            if (i_transfer_cmd == CMD_PC_MD)
                pc <= md[ADDR_W-1:0];
            else if (i_transfer_cmd == CMD_PC_AP)
                pc <= ap[ADDR_W-1:0];
            else if (i_inc_pc)
                pc <= pc + 1'b1;

            if (i_inc_dec_sp == 2'b01)
                sp <= sp + 1'b1;
            else if (i_inc_dec_sp == 2'b10)
                sp <= sp - 1'b1;

            case (i_transfer_cmd)
                CMD_MA_PC:  ma <= pc;
                CMD_MD_MEM: md <= rd_data;
                CMD_IR_MD:  ir <= md;
                CMD_MA_MD:  ma <= md[ADDR_W-1:0];
                CMD_R_MD:   if (i_dst_ap) ap <= md; else a <= md;
                CMD_MA_AP:  ma <= ap[ADDR_W-1:0];
                CMD_MA_SP:  ma <= sp;
                CMD_MD_R:   md <= i_dst_ap ? ap : a;
                CMD_R_ALU:  if (i_dst_ap) ap <= i_alu_result; else a <= i_alu_result;
                CMD_A_IN:   a  <= i_in_data;
                CMD_MD_PC:  md <= DATA_W'(pc);
                default:    ;
            endcase

            if (i_transfer_cmd == CMD_OUT_A) begin
                out_q     <= a;
                out_valid <= 1'b1;
                if (out_valid && !i_out_ready)
                    overrun <= 1'b1;
            end else if (out_valid && i_out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign o_opcode      = ir;
    assign o_a           = a;
    assign o_ap          = ap;
    assign o_md          = md;
    assign o_pc          = pc;
    assign o_sp          = sp;
    assign o_out_data    = out_q;
    assign o_out_valid   = out_valid;
    assign o_out_overrun = overrun;

endmodule

// File: tb/tb_transfer_datapath.sv
// Randomized scoreboard bench for transfer_datapath: a behavioural model predicts
// the register state after every edge and the sequence of consumed OUT words.
module tb_transfer_datapath;

    logic       i_clk, i_rstn;
    logic [3:0] i_transfer_cmd;
    logic       i_inc_pc, i_mem_we, i_dst_ap, i_out_ready, i_load_en;
    logic [1:0] i_inc_dec_sp;
    logic [7:0] i_alu_result, i_in_data, i_load_addr, i_load_data;
    logic [7:0] o_opcode, o_a, o_ap, o_md, o_pc, o_sp, o_out_data;
    logic       o_out_valid, o_out_overrun;

    transfer_datapath dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_transfer_cmd(i_transfer_cmd),
        .i_inc_pc(i_inc_pc), .i_inc_dec_sp(i_inc_dec_sp), .i_mem_we(i_mem_we),
        .i_dst_ap(i_dst_ap), .i_alu_result(i_alu_result), .i_in_data(i_in_data),
        .i_out_ready(i_out_ready), .i_load_en(i_load_en), .i_load_addr(i_load_addr),
        .i_load_data(i_load_data), .o_opcode(o_opcode), .o_a(o_a), .o_ap(o_ap),
        .o_md(o_md), .o_pc(o_pc), .o_sp(o_sp), .o_out_data(o_out_data),
        .o_out_valid(o_out_valid), .o_out_overrun(o_out_overrun)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [7:0] pc, sp, md, ir, a, ap, out;
        logic       valid, ovr;
    } snap_t;

    snap_t      sq[$];
    logic [7:0] oq[$];
    int         n_chk = 0;
    int         n_pass = 0;

    // reference state
    logic [7:0] m_mem [256];
    logic [7:0] m_pc, m_sp, m_ma, m_md, m_ir, m_a, m_ap, m_out;
    logic       m_valid, m_ovr;

    function automatic void chk(string name, logic [7:0] act, logic [7:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    endfunction

    function automatic void model_reset();
        m_pc = 8'h00; m_sp = 8'hFF; m_ma = 8'h00; m_md = 8'h00; m_ir = 8'h00;
        m_a = 8'h00; m_ap = 8'h00; m_out = 8'h00; m_valid = 1'b0; m_ovr = 1'b0;
    endfunction

    // one edge of the architectural rules, all sources taken before the edge
    function automatic void model_edge();
        logic [7:0] pc = m_pc, sp = m_sp, ma = m_ma, md = m_md, a = m_a, ap = m_ap;
        logic [7:0] rd = m_mem[m_ma];
        logic [7:0] sel = i_dst_ap ? ap : a;
        case (i_transfer_cmd)
            4'h1: m_ma = pc;
            4'h2: m_md = rd;
            4'h3: m_ir = md;
            4'h4: m_ma = md;
            4'h5: if (i_dst_ap) m_ap = md; else m_a = md;
            4'h6: m_ma = ap;
            4'h7: m_ma = sp;
            4'h8: m_md = sel;
            4'hA: if (i_dst_ap) m_ap = i_alu_result; else m_a = i_alu_result;
            4'hC: m_a = i_in_data;
            4'hF: m_md = pc;
            default: ;
        endcase
        if (i_transfer_cmd == 4'hB)      m_pc = md;
        else if (i_transfer_cmd == 4'hE) m_pc = ap;
        else if (i_inc_pc)               m_pc = pc + 8'd1;
        if (i_inc_dec_sp == 2'b01)      m_sp = sp + 8'd1;
        else if (i_inc_dec_sp == 2'b10) m_sp = sp - 8'd1;
        if (i_load_en) m_mem[i_load_addr] = i_load_data;
        else if (i_transfer_cmd == 4'h9 || i_mem_we) m_mem[ma] = md;
        if (i_transfer_cmd == 4'hD) begin
            // an unconsumed word being replaced is lost from the expected stream
            if (m_valid && !i_out_ready) begin
                m_ovr = 1'b1;
                if (oq.size() > 0) void'(oq.pop_back());
            end
            oq.push_back(a);
            m_out = a;
            m_valid = 1'b1;
        end else if (m_valid && i_out_ready) begin
            m_valid = 1'b0;
        end
    endfunction

    task automatic step(input logic [3:0] cmd, input logic inc = 1'b0,
                        input logic [1:0] spop = 2'b00, input logic dst = 1'b0,
                        input logic [7:0] r = 8'h00, input logic [7:0] ind = 8'h00,
                        input logic rdy = 1'b0);
        snap_t s;
        i_transfer_cmd = cmd; i_inc_pc = inc; i_inc_dec_sp = spop; i_dst_ap = dst;
        i_alu_result = r; i_in_data = ind; i_out_ready = rdy;
        model_edge();
        s.pc = m_pc; s.sp = m_sp; s.md = m_md; s.ir = m_ir; s.a = m_a; s.ap = m_ap;
        s.out = m_out; s.valid = m_valid; s.ovr = m_ovr;
        sq.push_back(s);
        @(posedge i_clk);
        #2;
        i_load_en = 1'b0; i_mem_we = 1'b0;
    endtask

    task automatic check_reset_values();
        chk("rst_pc", o_pc, 8'h00);
        chk("rst_sp", o_sp, 8'hFF);
        chk("rst_md", o_md, 8'h00);
        chk("rst_ir", o_opcode, 8'h00);
        chk("rst_a", o_a, 8'h00);
        chk("rst_ap", o_ap, 8'h00);
        chk("rst_valid", {7'd0, o_out_valid}, 8'h00);
        chk("rst_overrun", {7'd0, o_out_overrun}, 8'h00);
    endtask

    task automatic do_reset();
        i_rstn = 1'b0;
        #1;
        check_reset_values();
        model_reset();
        sq.delete();
        oq.delete();
        @(posedge i_clk);
        #2;
        i_rstn = 1'b1;
    endtask

    // register-state monitor: one expected snapshot per edge
    always @(posedge i_clk) begin
        #1;
        if (sq.size() > 0) begin
            snap_t e;
            e = sq.pop_front();
            chk("pc", o_pc, e.pc);
            chk("sp", o_sp, e.sp);
            chk("md", o_md, e.md);
            chk("ir", o_opcode, e.ir);
            chk("a", o_a, e.a);
            chk("ap", o_ap, e.ap);
            chk("out_data", o_out_data, e.out);
            chk("out_valid", {7'd0, o_out_valid}, {7'd0, e.valid});
            chk("overrun", {7'd0, o_out_overrun}, {7'd0, e.ovr});
        end
    end

    // output-port monitor: every accepted word must be the next expected one
    always @(negedge i_clk) begin
        if (i_rstn && o_out_valid && i_out_ready) begin
            if (oq.size() == 0) chk("out_word_unexpected", o_out_data, 8'hXX);
            else chk("out_word", o_out_data, oq.pop_front());
        end
    end

    initial begin
        i_rstn = 1'b0; i_transfer_cmd = 4'h0; i_inc_pc = 1'b0; i_inc_dec_sp = 2'b00;
        i_mem_we = 1'b0; i_dst_ap = 1'b0; i_alu_result = 8'h00; i_in_data = 8'h00;
        i_out_ready = 1'b0; i_load_en = 1'b0; i_load_addr = 8'h00; i_load_data = 8'h00;
        model_reset();

        // preload whole RAM while reset is held
        for (int i = 0; i < 259; i++) begin
            i_load_en = 1'b1;
            i_load_addr = (i == 256) ? 8'h00 : (i == 257) ? 8'h01 : (i == 258) ? 8'hFF : 8'(i);
            i_load_data = (i == 256) ? 8'h19 : (i == 257) ? 8'h5A : (i == 258) ? 8'hC3 : 8'($urandom);
            m_mem[i_load_addr] = i_load_data;
            @(posedge i_clk);
            #2;
        end
        i_load_en = 1'b0;
        check_reset_values();
        i_rstn = 1'b1;

        // fetch sequence
        step(4'h1, 1'b1);                chk("fetch_pc1", o_pc, 8'h01);
        step(4'h2);                      chk("fetch_md", o_md, 8'h19);
        step(4'h3);                      chk("opcode", o_opcode, 8'h19);
        step(4'h1, 1'b1);                chk("fetch_pc2", o_pc, 8'h02);
        step(4'h2);                      chk("operand_md", o_md, 8'h5A);

        // store A through MD to M[0x40] and read it back
        step(4'hC, 0, 2'b00, 0, 8'h00, 8'h33);
        step(4'hA, 0, 2'b00, 1, 8'h40);
        step(4'h6);
        step(4'h8, 0, 2'b00, 0);         chk("md_from_a", o_md, 8'h33);
        step(4'h9);
        step(4'h2);                      chk("readback_next", o_md, 8'h33);
        step(4'hF);                      chk("md_from_pc", o_md, 8'h02);
        step(4'h2);                      chk("readback_m40", o_md, 8'h33);

        // SP wrap and cmd 7 with decrement
        step(4'h0, 0, 2'b01);            chk("sp_wrap_up", o_sp, 8'h00);
        step(4'h0, 0, 2'b10);            chk("sp_wrap_down", o_sp, 8'hFF);
        step(4'h7, 0, 2'b10);            chk("sp_dec", o_sp, 8'hFE);
        step(4'h2);                      chk("ma_old_sp", o_md, 8'hC3);

        // OUT hold then accept
        step(4'hC, 0, 2'b00, 0, 8'h00, 8'h7E);
        step(4'hD);
        for (int i = 0; i < 3; i++) begin
            step(4'h0);
            chk("out_hold_valid", {7'd0, o_out_valid}, 8'h01);
            chk("out_hold_data", o_out_data, 8'h7E);
        end
        step(4'h0, 0, 2'b00, 0, 8'h00, 8'h00, 1'b1);
        chk("out_cleared", {7'd0, o_out_valid}, 8'h00);
        chk("no_overrun", {7'd0, o_out_overrun}, 8'h00);

        // overrun
        step(4'hC, 0, 2'b00, 0, 8'h00, 8'h01);
        step(4'hD);
        step(4'hC, 0, 2'b00, 0, 8'h00, 8'h02);
        step(4'hD);
        chk("overrun_data", o_out_data, 8'h02);
        chk("overrun_set", {7'd0, o_out_overrun}, 8'h01);
        step(4'h0, 0, 2'b00, 0, 8'h00, 8'h00, 1'b1);
        chk("overrun_sticky", {7'd0, o_out_overrun}, 8'h01);
        do_reset();

        // preload wins over a same-edge datapath write
        step(4'hA, 0, 2'b00, 1, 8'h10);
        step(4'h6);
        step(4'hA, 0, 2'b00, 0, 8'h55);
        step(4'h8);
        i_load_en = 1'b1; i_load_addr = 8'h10; i_load_data = 8'hAA;
        step(4'h9);
        step(4'h2);                      chk("load_priority", o_md, 8'hAA);

        // randomized traffic with a mid-run reset
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            i_load_en   = ($urandom_range(7) == 0);
            i_load_addr = 8'($urandom);
            i_load_data = 8'($urandom);
            i_mem_we    = ($urandom_range(7) == 0);
            step(4'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
                 8'($urandom), 8'($urandom), 1'($urandom));
        end

        step(4'h0);
        step(4'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
